// File: rtl/jk_cmd_sequencer.sv
// Command FIFO plus replay FSM that drives J/K of a downstream JK flop for cmd_len+1 cycles per command.
// Optional JKSEQ_SHADOW_EN adds a shadow JK model that flags a sticky mismatch against the flop's q.
module jk_cmd_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [CNT_W-1:0]           cmd_len,
  input  logic                       flush,
  output logic                       j,
  output logic                       k,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef JKSEQ_SHADOW_EN
  ,
  input  logic                       q_fb,
  output logic                       mismatch
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned EW = 2 + CNT_W;

  typedef enum logic {IDLE, DRIVE} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             j_q, j_d, k_q, k_d, busy_q, busy_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    head;
  logic             empty, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = cmd_valid && ready_q && !flush;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Storage carries no reset; only pointer-qualified entries are ever read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_len};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      cnt_q    <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!empty) state_d = DRIVE;
        DRIVE:   if (cnt_q == '0 && empty) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A finished command hands straight over to the next queued one, so there is no bubble.
  always_comb begin
    pop    = 1'b0;
    cnt_d  = cnt_q;
    j_d    = j_q;
    k_d    = k_q;
    busy_d = busy_q;
    if (flush) begin
      cnt_d  = '0;
      j_d    = 1'b0;
      k_d    = 1'b0;
      busy_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          j_d    = 1'b0;
          k_d    = 1'b0;
          busy_d = 1'b0;
          if (!empty) begin
            pop        = 1'b1;
            {j_d, k_d} = head[EW-1 -: 2];
            cnt_d      = head[CNT_W-1:0];
            busy_d     = 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (!empty) begin
            pop        = 1'b1;
            {j_d, k_d} = head[EW-1 -: 2];
            cnt_d      = head[CNT_W-1:0];
            busy_d     = 1'b1;
          end else begin
            j_d    = 1'b0;
            k_d    = 1'b0;
            busy_d = 1'b0;
          end
        end
        default: begin
          j_d    = 1'b0;
          k_d    = 1'b0;
          busy_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = '0;
    rd_ptr_d = '0;
    level_d  = '0;
    ready_d  = 1'b1;
    if (!flush) begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      level_d  = level_q + LW'(push) - LW'(pop);
      ready_d  = (level_d != LW'(DEPTH));
    end
  end

  assign cmd_ready = ready_q;
  assign j         = j_q;
  assign k         = k_q;
  assign busy      = busy_q;
  assign level     = level_q;

`ifdef JKSEQ_SHADOW_EN
  logic qm_q, qm_d, armed_q, armed_d, mis_q, mis_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qm_q    <= 1'b0;
      armed_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      qm_q    <= qm_d;
      armed_q <= armed_d;
      mis_q   <= mis_d;
    end
  end

  // The flop has no reset, so comparison only starts once a set or clear has defined it.
  always_comb begin
    qm_d    = qm_q;
    armed_d = armed_q;
    mis_d   = mis_q;
    if (flush) begin
      qm_d    = 1'b0;
      armed_d = 1'b0;
      mis_d   = 1'b0;
    end else begin
      if (armed_q && (q_fb != qm_q)) mis_d = 1'b1;
      if (j_q ^ k_q) armed_d = 1'b1;
      case ({j_q, k_q})
        2'b01:   qm_d = 1'b0;
        2'b10:   qm_d = 1'b1;
        2'b11:   qm_d = ~qm_q;
        default: qm_d = qm_q;
      endcase
    end
  end

  assign mismatch = mis_q;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Randomized bench for jk_cmd_sequencer checked against a queue-based command model every cycle.
module tb_jk_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic             flush;
  logic             j, k, busy;
  logic [LW-1:0]    level;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  typedef struct {
    logic [1:0] op;
    int         len;
  } mcmd_t;

  mcmd_t      mq[$];
  bit         m_active;
  logic [1:0] m_op;
  int         m_rem;

`ifdef JKSEQ_SHADOW_EN
  logic q_fb, mismatch;
  logic flop_q = 1'b0;
  bit   force_zero = 0;
  bit   m_armed, m_qm, m_mis;

  always @(posedge clk) begin
    case ({j, k})
      2'b01:   flop_q <= 1'b0;
      2'b10:   flop_q <= 1'b1;
      2'b11:   flop_q <= ~flop_q;
      default: flop_q <= flop_q;
    endcase
  end
  assign q_fb = force_zero ? 1'b0 : flop_q;
`endif

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .flush     (flush),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .level     (level)
`ifdef JKSEQ_SHADOW_EN
    ,
    .q_fb      (q_fb),
    .mismatch  (mismatch)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 0;
    m_op     = 2'b00;
    m_rem    = 0;
`ifdef JKSEQ_SHADOW_EN
    m_armed = 0;
    m_qm    = 0;
    m_mis   = 0;
`endif
  endtask

  // One clock edge of the command model: drive time counts down, then the next queued command takes over.
  task automatic model_step(input bit v, input logic [1:0] op, input int len, input bit fl);
    logic [1:0] jk_now;
    bit         had_cmd, acc;
    jk_now = m_active ? m_op : 2'b00;
`ifdef JKSEQ_SHADOW_EN
    if (fl) begin
      m_armed = 0; m_qm = 0; m_mis = 0;
    end else begin
      if (m_armed && (q_fb != m_qm)) m_mis = 1;
      if (jk_now == 2'b01 || jk_now == 2'b10) m_armed = 1;
      if (jk_now == 2'b01) m_qm = 0;
      else if (jk_now == 2'b10) m_qm = 1;
      else if (jk_now == 2'b11) m_qm = !m_qm;
    end
`endif
    if (fl) begin
      mq.delete();
      m_active = 0;
      return;
    end
    had_cmd = (mq.size() > 0);
    acc     = v && (mq.size() < DEPTH);
    if (m_active && m_rem > 1) begin
      m_rem--;
    end else if (had_cmd) begin
      mcmd_t c;
      c        = mq.pop_front();
      m_op     = c.op;
      m_rem    = c.len + 1;
      m_active = 1;
    end else begin
      m_active = 0;
    end
    if (acc) mq.push_back('{op: op, len: len});
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("j",     int'(j),         m_active ? int'(m_op[1]) : 0);
      chk("k",     int'(k),         m_active ? int'(m_op[0]) : 0);
      chk("busy",  int'(busy),      int'(m_active));
      chk("level", int'(level),     mq.size());
      chk("ready", int'(cmd_ready), int'(mq.size() < DEPTH));
`ifdef JKSEQ_SHADOW_EN
      chk("mismatch", int'(mismatch), int'(m_mis));
`endif
    end
  end

  task automatic tick(input bit v, input logic [1:0] op, input int len, input bit fl);
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = CNT_W'(len);
    flush     = fl;
    @(posedge clk);
    model_step(v, op, len, fl);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 2'b00, 0, 0);
  endtask

  task automatic do_reset();
    cmd_valid = 0;
    flush     = 0;
    rst_n     = 1'b0;
    #1;
    chk("rst_j",     int'(j),         0);
    chk("rst_k",     int'(k),         0);
    chk("rst_busy",  int'(busy),      0);
    chk("rst_level", int'(level),     0);
    chk("rst_ready", int'(cmd_ready), 1);
`ifdef JKSEQ_SHADOW_EN
    chk("rst_mismatch", int'(mismatch), 0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 0;
    cmd_op    = 2'b00;
    cmd_len   = '0;
    flush     = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1;

    // Single set, len 2: driven after three edges following the pop.
    tick(1, 2'b10, 2, 0);
    chk("set_lvl1",  int'(level), 1);
    chk("set_nobyp", int'(busy),  0);
    tick(0, 2'b00, 0, 0);
    chk("set_j1", int'({j, k}), 2);
    chk("set_busy", int'(busy), 1);
    idle(2);
    chk("set_j3", int'({j, k}), 2);
    idle(1);
    chk("set_done_jk",   int'({j, k}), 0);
    chk("set_done_busy", int'(busy),   0);

    // Back-to-back clear then toggle with no bubble.
    tick(1, 2'b01, 0, 0);
    tick(1, 2'b11, 1, 0);
    chk("b2b_clr", int'({j, k}), 1);
    idle(1);
    chk("b2b_tg1", int'({j, k}), 3);
    idle(1);
    chk("b2b_tg2", int'({j, k}), 3);
    idle(1);
    chk("b2b_end", int'({j, k}), 0);

    // Fill the FIFO behind a long command; the overflow push is dropped.
    tick(1, 2'b10, 15, 0);
    tick(1, 2'b01, 1, 0);
    tick(1, 2'b11, 2, 0);
    tick(1, 2'b00, 3, 0);
    tick(1, 2'b10, 0, 0);
    chk("full_lvl",   int'(level),     4);
    chk("full_ready", int'(cmd_ready), 0);
    tick(1, 2'b01, 5, 0);
    chk("full_hold", int'(level), 4);
    tick(0, 2'b00, 0, 1);

    // Flush mid-drive with three queued and a simultaneous push.
    tick(1, 2'b10, 15, 0);
    tick(1, 2'b01, 3, 0);
    tick(1, 2'b01, 3, 0);
    tick(1, 2'b11, 3, 0);
    chk("fl_pre_lvl", int'(level), 3);
    tick(1, 2'b11, 0, 1);
    chk("fl_jk",    int'({j, k}), 0);
    chk("fl_level", int'(level),  0);
    chk("fl_busy",  int'(busy),   0);
    idle(1);
    chk("fl_lost", int'(level), 0);
    chk("fl_idle", int'(busy),  0);

`ifdef JKSEQ_SHADOW_EN
    tick(1, 2'b10, 1, 0);
    tick(1, 2'b11, 2, 0);
    idle(6);
    chk("sh_clean", int'(mismatch), 0);
    tick(1, 2'b10, 3, 0);
    idle(2);
    force_zero = 1;
    idle(1);
    chk("sh_hit", int'(mismatch), 1);
    force_zero = 0;
    idle(3);
    chk("sh_sticky", int'(mismatch), 1);
    tick(0, 2'b00, 0, 1);
    chk("sh_flush", int'(mismatch), 0);
`endif

    // Mid-drive async reset.
    tick(1, 2'b11, 9, 0);
    idle(2);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        int len;
        len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
        tick($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), len,
             $urandom_range(0, 59) == 0);
      end
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
- Upstream driver for the JK flip-flop stage: accepts set/clear/toggle/hold commands over a valid/ready interface.
- Buffers commands in a small FIFO and replays each one on the J/K outputs for a programmable number of consecutive clock cycles.
- J/K outputs connect directly to the flop's J/K inputs on the same clock.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2
CNT_W, 4, width of per-command repeat field

Ports:
clk  input  1  rising-edge clock shared with the downstream flop
rst_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; equals !full
cmd_op  input  2  {J,K} encoding: 00 hold, 01 clear, 10 set, 11 toggle
cmd_len  input  CNT_W  drive duration minus one (cycles = cmd_len+1)
flush  input  1  synchronous abort: empty FIFO, stop driving
j  output  1  registered J to flop
k  output  1  registered K to flop
busy  output  1  1 while a command is being driven
level  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst_n low, async): j=0, k=0, busy=0, level=0, FIFO pointers 0, state IDLE; cmd_ready=1 once FIFO empty (immediately).
- Push: on a rising edge with cmd_valid && cmd_ready, {cmd_op,cmd_len} is written; level increments.
- FSM states: IDLE, DRIVE.
- IDLE: j=k=0, busy=0. If FIFO non-empty at a clock edge: pop head, load {j,k}=op, cnt=len, go to DRIVE.
- No bypass: a command pushed into an empty FIFO at edge N is popped at edge N+1; j/k valid after edge N+1.
- DRIVE: busy=1; j/k held. Each edge with cnt!=0, cnt decrements.
- DRIVE, edge with cnt==0:
  - FIFO non-empty: pop next back-to-back with no bubble cycle.
  - FIFO empty: j=k=0, go to IDLE.
- Each command is therefore driven for exactly cmd_len+1 cycles.
- Simultaneous push and pop in one edge: both occur; level unchanged.
- Full FIFO: cmd_ready=0; cmd_valid ignored, no overwrite.
- flush (highest priority over push and pop): at that edge FIFO cleared (level=0), j=k=0, busy=0, state IDLE; a push in the same cycle is discarded.
- Reset mid-DRIVE: outputs return to reset values immediately (asynchronously).
- Counter and pointers wrap modulo their width; pointers use one extra bit to distinguish full from empty.

Optional Feature:
Macro JKSEQ_SHADOW_EN.
- Defined:
  - Extra ports: q_fb input 1 (flop output q) and mismatch output 1.
  - Internal q_model tracks JK semantics each edge from registered j/k: 00 hold, 01 ->0, 10 ->1, 11 invert.
  - Checking arms after the first set or clear has been driven, since the flop has no reset.
  - Once armed: mismatch is set sticky if q_fb != q_model at an edge.
  - flush and reset clear mismatch, arm state and q_model (q_model resets to 0).
- Undefined: ports, model and checker absent; all other behaviour identical.

Test Plan:
- Reset check: rst_n=0 mid-run -> j=k=0, busy=0, level=0, cmd_ready=1 before the next edge.
- Single set: push op=10, len=2 into empty FIFO at edge N -> j=1,k=0 after edges N+1..N+3; j=k=0 and busy=0 after edge N+4.
- Back-to-back: push clear len=0, then toggle len=1, with DEPTH=4 -> j,k = 01 for 1 cycle, then 11 for 2 cycles, no idle cycle between.
- Full: push 5 commands while the first is driving with len=15 -> cmd_ready=0 at level=4, 5th push not accepted, level stays 4.
- Flush: flush=1 during DRIVE with level=3 and cmd_valid=1 -> next cycle j=k=0, level=0, busy=0, pushed command lost.
- JKSEQ_SHADOW_EN: drive set, then toggle, with q_fb tied from a correct flop -> mismatch=0; force q_fb=0 after the set -> mismatch=1 and stays 1 until flush.
